cr_fifo_rd_stage: RTL and testbench



---
 rtl/cr_fifo_rd_stage.sv | 115 +++++++++++
 tb/tb_cr_fifo_rd_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cr_fifo_rd_stage.sv
// cr_fifo_rd_stage
// Read-side drain stage for the cr_ FIFO wrappers. Pops words from a
// show-ahead FIFO read port and presents them on a registered valid/ready
// output through a 2-entry skid buffer. fifo_ren depends only on local state,
// drain_en, fifo_empty and rst_n, so downstream ready paths never reach the
// FIFO pointer logic.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   fifo_rdata     FIFO head word (valid while fifo_empty = 0)
//   fifo_empty     FIFO empty flag
//   fifo_overflow  FIFO overflow pulse
//   fifo_ren       pop request to the FIFO
//   drain_en       0 pauses popping; buffered words still drain
//   out_valid      out_data is valid
//   out_data       head of the skid buffer
//   out_ready      downstream accepts the word when out_valid = 1
//   stage_cnt      words buffered (0..2)
//   pop_cnt        words accepted downstream, wrapping
//   ovf_err        sticky overflow flag, cleared only by reset
module cr_fifo_rd_stage #(
  parameter int N_DATA_BITS = 64,
  parameter int N_CNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_DATA_BITS-1:0] fifo_rdata,
  input  logic                   fifo_empty,
  input  logic                   fifo_overflow,
  output logic                   fifo_ren,
  input  logic                   drain_en,
  output logic                   out_valid,
  output logic [N_DATA_BITS-1:0] out_data,
  input  logic                   out_ready,
  output logic [1:0]             stage_cnt,
  output logic [N_CNT_BITS-1:0]  pop_cnt,
  output logic                   ovf_err
);

  logic [N_DATA_BITS-1:0] slot0_q, slot0_d;
  logic [N_DATA_BITS-1:0] slot1_q, slot1_d;
  logic [1:0]             cnt_q,   cnt_d;
  logic [N_CNT_BITS-1:0]  pop_cnt_q, pop_cnt_d;
  logic                   ovf_err_q, ovf_err_d;
  logic                   push;
  logic                   pop;

  // Pop only while a slot is free; out_ready is deliberately not used here.
  assign fifo_ren = rst_n & drain_en & ~fifo_empty & (cnt_q != 2'd2);

  assign push = fifo_ren;
  assign pop  = (cnt_q != 2'd0) & out_ready;

  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    cnt_d     = cnt_q;
    pop_cnt_d = pop_cnt_q;
    ovf_err_d = ovf_err_q | fifo_overflow;

    case (cnt_q)
      2'd0: begin
        if (push) begin
          slot0_d = fifo_rdata;
          cnt_d   = 2'd1;
        end
      end
      2'd1: begin
        // Push and pop together replace the head in place.
        if (push && pop) begin
          slot0_d = fifo_rdata;
        end else if (push) begin
          slot1_d = fifo_rdata;
          cnt_d   = 2'd2;
        end else if (pop) begin
          cnt_d   = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          slot0_d = slot1_q;
          cnt_d   = 2'd1;
        end
      end
      default: cnt_d = '0;
    endcase

    if (pop) begin
      pop_cnt_d = pop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q   <= '0;
      slot1_q   <= '0;
      cnt_q     <= '0;
      pop_cnt_q <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      cnt_q     <= cnt_d;
      pop_cnt_q <= pop_cnt_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign out_data  = slot0_q;
  assign out_valid = (cnt_q != 2'd0);
  assign stage_cnt = cnt_q;
  assign pop_cnt   = pop_cnt_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_cr_fifo_rd_stage.sv
// Testbench for cr_fifo_rd_stage. A queue models the show-ahead FIFO; words
// handed to the DUT are pushed into a scoreboard queue and a negedge monitor
// checks every output against that queue. A second instance with a 4-bit pop
// counter shares all inputs to exercise counter wrap.
module tb_cr_fifo_rd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_overflow;
  logic        fifo_ren;
  logic        drain_en;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [1:0]  stage_cnt;
  logic [15:0] pop_cnt;
  logic        ovf_err;

  logic        fifo_ren4;
  logic        out_valid4;
  logic [63:0] out_data4;
  logic [1:0]  stage_cnt4;
  logic [3:0]  pop_cnt4;
  logic        ovf_err4;

  always #5 clk = ~clk;

  cr_fifo_rd_stage #(.N_DATA_BITS(64), .N_CNT_BITS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_overflow(fifo_overflow), .fifo_ren(fifo_ren), .drain_en(drain_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_cnt(stage_cnt), .pop_cnt(pop_cnt), .ovf_err(ovf_err)
  );

  cr_fifo_rd_stage #(.N_DATA_BITS(64), .N_CNT_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_overflow(fifo_overflow), .fifo_ren(fifo_ren4), .drain_en(drain_en),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .stage_cnt(stage_cnt4), .pop_cnt(pop_cnt4), .ovf_err(ovf_err4)
  );

  logic [63:0]  fifo_q[$];   // behavioural FIFO contents
  logic [63:0]  exp_q[$];    // words handed to the DUT, not yet accepted
  int unsigned  exp_pop   = 0;
  logic         exp_ovf   = 1'b0;
  logic         exp_zero  = 1'b0;
  logic         mon_en    = 1'b0;
  int unsigned  n_checks  = 0;
  int unsigned  n_fail    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the outputs presented in this cycle with the model.
  always @(negedge clk) begin
    if (mon_en) begin
      int unsigned sz;
      logic        exp_ren;
      sz      = exp_q.size();
      exp_ren = rst_n && drain_en && (fifo_q.size() != 0) && (sz < 2);
      chk("out_valid", {63'd0, out_valid}, {63'd0, sz != 0});
      if (sz != 0)
        chk("out_data", out_data, exp_q[0]);
      else if (exp_zero)
        chk("out_data_after_reset", out_data, 64'd0);
      chk("stage_cnt", {62'd0, stage_cnt}, 64'(sz));
      chk("stage_cnt_max", {63'd0, stage_cnt > 2'd2}, 64'd0);
      chk("pop_cnt", {48'd0, pop_cnt}, 64'(exp_pop % 65536));
      chk("pop_cnt_w4", {60'd0, pop_cnt4}, 64'(exp_pop % 16));
      chk("ovf_err", {63'd0, ovf_err}, {63'd0, exp_ovf});
      chk("fifo_ren", {63'd0, fifo_ren}, {63'd0, exp_ren});
      chk("fifo_ren_w4", {63'd0, fifo_ren4}, {63'd0, exp_ren});
      chk("ren_while_empty", {63'd0, fifo_ren && fifo_empty}, 64'd0);
      if (out_valid && out_ready && sz != 0) begin
        void'(exp_q.pop_front());
        exp_pop++;
      end
    end
  end

  // One clock of stimulus: drive inputs just after the rising edge, note the
  // pop request mid-cycle, then apply the FIFO/model effects of the edge.
  task automatic cycle(input logic rdy, input logic den, input logic ovf, input logic rn);
    logic ren_s;
    out_ready     = rdy;
    drain_en      = den;
    fifo_overflow = ovf;
    rst_n         = rn;
    fifo_empty    = (fifo_q.size() == 0);
    fifo_rdata    = fifo_empty ? {$urandom, $urandom} : fifo_q[0];
    @(negedge clk);
    ren_s = fifo_ren;
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_q.delete();
      fifo_q.delete();
      exp_pop  = 0;
      exp_ovf  = 1'b0;
      exp_zero = 1'b1;
    end else begin
      if (ren_s && fifo_q.size() != 0) begin
        exp_q.push_back(fifo_q.pop_front());
        exp_zero = 1'b0;
      end
      if (ovf) exp_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    mon_en = 1'b1;
  endtask

  task automatic drain_all(input string name);
    int unsigned budget;
    budget = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && budget < 3000) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      budget++;
    end
    chk(name, 64'(exp_q.size() + fifo_q.size()), 64'd0);
  endtask

  initial begin
    int unsigned gen;
    rst_n = 1'b0; out_ready = 1'b0; drain_en = 1'b1; fifo_overflow = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = '0;
    @(posedge clk); #1;
    do_reset();
    do_reset();

    // Reset state and first pop: two preloaded words, downstream stalled.
    fifo_q.push_back(64'hA);
    fifo_q.push_back(64'hB);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("first_pop_cnt2", {62'd0, stage_cnt}, 64'd2);
    chk("first_pop_head", out_data, 64'hA);

    // Reset mid-stream with two words buffered.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Streaming 100 incrementing words with ready held high.
    for (int i = 0; i < 100; i++) fifo_q.push_back(64'(i));
    drain_all("stream_timeout");
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("stream_pop_cnt", {48'd0, pop_cnt}, 64'd100);

    // drain_en pause while streaming at one buffered word.
    for (int i = 0; i < 10; i++) fifo_q.push_back(64'h1000 + 64'(i));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pause_empty", {63'd0, out_valid}, 64'd0);
    drain_all("pause_timeout");

    // Overflow pulse: sticky until reset.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) fifo_q.push_back(64'h2000 + 64'(i));
    drain_all("wrap_timeout");
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("wrap_pop_cnt_w4", {60'd0, pop_cnt4}, 64'd1);

    // Random backpressure and arrivals, 1000 words.
    do_reset();
    gen = 0;
    while (gen < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        fifo_q.push_back({$urandom, $urandom});
        gen++;
      end
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 1'b0, 1'b1);
    end
    begin
      int unsigned budget;
      budget = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0) && budget < 5000) begin
        cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        budget++;
      end
      chk("random_timeout", 64'(exp_q.size() + fifo_q.size()), 64'd0);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("random_pop_cnt", {48'd0, pop_cnt}, 64'd1000);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
